main_controller_fsm: RTL and testbench

MAIN_CONTROLLER_FSM -- requirements
Module: main_controller_fsm

---
 rtl/main_controller_fsm.sv | 197 +++++++++++++++++++
 tb/tb_main_controller_fsm.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/main_controller_fsm.sv
// Multicycle RISC-V main controller: sequences fetch/decode/execute/writeback
// and decodes datapath selects, write enables and ALU opcode from the state.
// Optional feature: define MAIN_CONTROLLER_BNE_EN to let funct3=001 branches
// (bne) take when the ALU zero flag is clear.
module main_controller_fsm #(
    parameter int unsigned CONTROL = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               zero,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ImmSrc,
    output logic               RegWrite,
    output logic [CONTROL-1:0] ALUControl,
    output logic [3:0]         state
);

    localparam int unsigned STATE_W = 4;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } alu_op_t;

    state_t     state_q, state_d;
    alu_op_t    alu_op;
    logic       pc_update, branch, taken, legal_state;
    logic       mem_write, ir_write, reg_write;
    logic [2:0] alu_ctrl;

    // State register with synchronous reset to FETCH
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next-state and Moore output decode
    always_comb begin
        state_d     = S_FETCH;
        legal_state = 1'b1;
        pc_update   = 1'b0;
        branch      = 1'b0;
        alu_op      = ALUOP_ADD;
        AdrSrc      = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        case (state_q)
            S_FETCH: begin
                state_d   = S_DECODE;
                ir_write  = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pc_update = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BR:        state_d = S_BEQ;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                state_d = S_MEMWB;
                AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTER: begin
                state_d = S_ALUWB;
                ALUSrcA = 2'b10;
                alu_op  = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                state_d = S_ALUWB;
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_JAL: begin
                state_d   = S_ALUWB;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                branch  = 1'b1;
                alu_op  = ALUOP_SUB;
            end
            default: begin
                legal_state = 1'b0;
            end
        endcase
    end

    // ALU opcode decode; R-type sub needs op[5] so addi never becomes sub
    always_comb begin
        alu_ctrl = 3'b000;
        case (alu_op)
            ALUOP_SUB: alu_ctrl = 3'b001;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_ctrl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alu_ctrl = 3'b101;
                    3'b110:  alu_ctrl = 3'b011;
                    3'b111:  alu_ctrl = 3'b010;
                    default: alu_ctrl = 3'b000;
                endcase
            end
            default: alu_ctrl = 3'b000;
        endcase
    end

    // Branch condition from the ALU zero flag
    always_comb begin
        taken = 1'b0;
        if (funct3 == 3'b000) taken = zero;
`ifdef MAIN_CONTROLLER_BNE_EN
        else if (funct3 == 3'b001) taken = ~zero;
`endif
    end

    // Immediate format from opcode; quiet in unreachable states
    always_comb begin
        ImmSrc = 2'b00;
        if (legal_state) begin
            case (op)
                OP_SW:   ImmSrc = 2'b01;
                OP_BR:   ImmSrc = 2'b10;
                OP_JAL:  ImmSrc = 2'b11;
                default: ImmSrc = 2'b00;
            endcase
        end
    end

    assign PCWrite    = ~reset & (pc_update | (branch & taken));
    assign MemWrite   = ~reset & mem_write;
    assign IRWrite    = ~reset & ir_write;
    assign RegWrite   = ~reset & reg_write;
    assign ALUControl = CONTROL'(alu_ctrl);
    assign state      = state_q;

endmodule

// File: tb/tb_main_controller_fsm.sv
// Randomized and directed bench for main_controller_fsm against an
// instruction-level reference model (class of instruction + cycle index).
module tb_main_controller_fsm;

    localparam int unsigned CONTROL = 3;
`ifdef MAIN_CONTROLLER_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    logic               clk;
    logic               reset;
    logic [6:0]         op;
    logic [2:0]         funct3;
    logic               funct7b5;
    logic               zero;
    logic               PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0]         ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [CONTROL-1:0] ALUControl;
    logic [3:0]         state;

    int vectors = 0;
    int errors  = 0;

    main_controller_fsm #(.CONTROL(CONTROL)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .PCWrite(PCWrite),
        .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .RegWrite(RegWrite), .ALUControl(ALUControl),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {C_LW, C_SW, C_R, C_I, C_JAL, C_BR, C_ILL} cls_t;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, adr, memw, irw;
        logic [1:0] res, sa, sb, imm;
        logic       regw;
        logic [2:0] alu;
    } obs_t;

    function automatic cls_t classify(input logic [6:0] o);
        case (o)
            7'b0000011: return C_LW;
            7'b0100011: return C_SW;
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b1101111: return C_JAL;
            7'b1100011: return C_BR;
            default:    return C_ILL;
        endcase
    endfunction

    // Cycles from FETCH back to FETCH for each instruction class
    function automatic int instr_len(input cls_t c);
        case (c)
            C_LW:    return 5;
            C_BR:    return 3;
            C_ILL:   return 2;
            default: return 4;
        endcase
    endfunction

    // Debug state number visited at cycle k of an instruction
    function automatic logic [3:0] exp_state(input cls_t c, input int k);
        if (k == 0) return 4'd0;
        if (k == 1) return 4'd1;
        if (k == 2) begin
            case (c)
                C_LW, C_SW: return 4'd2;
                C_R:        return 4'd6;
                C_I:        return 4'd8;
                C_JAL:      return 4'd9;
                default:    return 4'd10;
            endcase
        end
        if (k == 3) begin
            if (c == C_LW) return 4'd3;
            if (c == C_SW) return 4'd5;
            return 4'd7;
        end
        return 4'd4;
    endfunction

    function automatic logic [2:0] alu_fn(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0:    return (o[5] && f7) ? 3'd1 : 3'd0;
            3'd2:    return 3'd5;
            3'd6:    return 3'd3;
            3'd7:    return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    // Expected outputs at cycle k of an instruction
    function automatic obs_t model(input cls_t c, input int k, input logic [6:0] o,
                                   input logic [2:0] f3, input logic f7, input logic z);
        obs_t e;
        e = '0;
        e.st  = exp_state(c, k);
        e.imm = (c == C_SW) ? 2'd1 : (c == C_BR) ? 2'd2 : (c == C_JAL) ? 2'd3 : 2'd0;
        if (k == 0) begin
            e.irw = 1'b1; e.sb = 2'd2; e.res = 2'd2; e.pcw = 1'b1;
        end else if (k == 1) begin
            e.sa = 2'd1; e.sb = 2'd1;
        end else begin
            case (c)
                C_LW, C_SW: begin
                    if (k == 2) begin e.sa = 2'd2; e.sb = 2'd1; end
                    else if (k == 3) begin e.adr = 1'b1; e.memw = (c == C_SW); end
                    else begin e.res = 2'd1; e.regw = 1'b1; end
                end
                C_R, C_I: begin
                    if (k == 2) begin
                        e.sa = 2'd2; e.sb = (c == C_I) ? 2'd1 : 2'd0;
                        e.alu = alu_fn(o, f3, f7);
                    end else e.regw = 1'b1;
                end
                C_JAL: begin
                    if (k == 2) begin e.sa = 2'd1; e.sb = 2'd2; e.pcw = 1'b1; end
                    else e.regw = 1'b1;
                end
                default: begin
                    e.sa  = 2'd2; e.alu = 3'd1;
                    e.pcw = ((f3 == 3'd0) && z) || (BNE_EN && (f3 == 3'd1) && !z);
                end
            endcase
        end
        return e;
    endfunction

    // Runs one instruction from FETCH; optionally asserts reset at cycle rst_at
    task automatic test_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                              input int zsel, input int rst_at);
        cls_t c;
        obs_t e, a;
        c = classify(o);
        for (int k = 0; k < instr_len(c); k++) begin
            op = o; funct3 = f3; funct7b5 = f7;
            zero = (zsel == 2) ? 1'($urandom_range(0, 1)) : zsel[0];
            if (k == rst_at) begin
                reset = 1'b1;
                #1;
                vectors++;
                if (PCWrite !== 1'b0 || MemWrite !== 1'b0 || RegWrite !== 1'b0 ||
                    IRWrite !== 1'b0 || state !== exp_state(c, k)) begin
                    errors++;
                    $display("FAIL reset_mid op=%b k=%0d got st=%0d pcw=%b mw=%b rw=%b irw=%b exp st=%0d enables=0",
                             o, k, state, PCWrite, MemWrite, RegWrite, IRWrite, exp_state(c, k));
                end
                @(negedge clk);
                reset = 1'b0;
                #1;
                vectors++;
                if (state !== 4'd0 || IRWrite !== 1'b1 || PCWrite !== 1'b1) begin
                    errors++;
                    $display("FAIL reset_recover op=%b got st=%0d irw=%b pcw=%b exp st=0 irw=1 pcw=1",
                             o, state, IRWrite, PCWrite);
                end
                return;
            end
            #1;
            e = model(c, k, o, f3, f7, zero);
            a = '{state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                  ALUSrcB, ImmSrc, RegWrite, ALUControl[2:0]};
            vectors++;
            if (a !== e) begin
                errors++;
                $display("FAIL instr op=%b f3=%0d f7=%b z=%b k=%0d got=%h exp=%h",
                         o, f3, f7, zero, k, a, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; op = 7'h7F; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            vectors++;
            if (state !== 4'd0 || PCWrite !== 1'b0 || MemWrite !== 1'b0 ||
                RegWrite !== 1'b0 || IRWrite !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold got st=%0d pcw=%b mw=%b rw=%b irw=%b exp st=0 enables=0",
                         state, PCWrite, MemWrite, RegWrite, IRWrite);
            end
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (state !== 4'd0 || IRWrite !== 1'b1 || PCWrite !== 1'b1 || ALUSrcB !== 2'b10 ||
            ResultSrc !== 2'b10 || ALUControl !== '0) begin
            errors++;
            $display("FAIL reset_release got st=%0d irw=%b pcw=%b srcb=%b res=%b alu=%b exp 0/1/1/10/10/000",
                     state, IRWrite, PCWrite, ALUSrcB, ResultSrc, ALUControl);
        end
    endtask

    task automatic test_random(input int n);
        logic [6:0] ops [6];
        logic [6:0] o;
        int         r;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};
        for (int i = 0; i < n; i++) begin
            r = int'($urandom_range(0, 7));
            o = (r < 6) ? ops[r] : 7'($urandom);
            r = -1;
            if ($urandom_range(0, 9) == 0)
                r = int'($urandom_range(0, 32'(instr_len(classify(o)) - 1)));
            test_instr(o, 3'($urandom), 1'($urandom), 2, r);
        end
    endtask

    initial begin
        test_reset();
        test_instr(7'b0000011, 3'd2, 1'b0, 2, -1);   // lw
        test_instr(7'b0110011, 3'd0, 1'b1, 2, -1);   // sub
        test_instr(7'b0110011, 3'd6, 1'b0, 2, -1);   // or
        test_instr(7'b0010011, 3'd0, 1'b1, 2, -1);   // addi with bit30 set
        test_instr(7'b1100011, 3'd0, 1'b0, 1, -1);   // beq taken
        test_instr(7'b1100011, 3'd0, 1'b0, 0, -1);   // beq not taken
        test_instr(7'b1100011, 3'd1, 1'b0, 0, -1);   // bne, zero clear
        test_instr(7'b1100011, 3'd1, 1'b0, 1, -1);   // bne, zero set
        test_instr(7'b1101111, 3'd0, 1'b0, 2, -1);   // jal
        test_instr(7'b0100011, 3'd2, 1'b0, 2, -1);   // sw
        test_instr(7'b1111111, 3'd0, 1'b0, 2, -1);   // illegal
        test_instr(7'b0100011, 3'd2, 1'b0, 2, 3);    // reset in MEMWRITE
        test_instr(7'b0000011, 3'd2, 1'b0, 2, 4);    // reset in MEMWB
        test_instr(7'b1101111, 3'd0, 1'b0, 2, 2);    // reset in JAL
        test_instr(7'b0110011, 3'd0, 1'b0, 2, 0);    // reset in FETCH
        test_random(300);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
